kbd_fifo: RTL and testbench

Keyboard event buffer between `ps2keyboard` and `memctrl`. It takes raw PS/2 set-2 bytes from the one-cycle `received_data_en` strobe. It folds the `E0` (extended) and `F0` (release) prefixes into flags on the following code byte. Each complete key event goes into a 16-entry FIFO. The CPU drains the FIFO through `memctrl` with a pop strobe, so no keystroke is lost while the CPU is busy.

---
 rtl/kbd_fifo.sv | 136 +++++++++++++
 tb/tb_kbd_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/kbd_fifo.sv
// kbd_fifo: PS/2 set-2 key event buffer between the keyboard receiver and the memory controller.
//
// A prefix state machine folds the E0 (extended) and F0 (release) bytes into flag bits on
// the code byte that follows them. Each complete event {ext, rel, code} is pushed into a
// FIFO with 2^DEPTH_LOG2 entries. The CPU pops one entry on each rising edge of rd.
//
// Ports:
//   clock      in   system clock (same domain as the PS/2 receiver)
//   reset_n    in   asynchronous active-low reset
//   ps2_data   in   [7:0] received byte, valid while ps2_hit is high
//   ps2_hit    in   one-cycle strobe for ps2_data
//   rd         in   pop request, level; one pop is taken per rising edge
//   clr        in   synchronous flush, level
//   kbd_data   out  [7:0] head scancode, 0 when empty
//   kbd_flags  out  [7:0] {nonempty, overflow, release, extended, 4'b0}
//   kbd_count  out  [DEPTH_LOG2:0] number of stored entries
module kbd_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_hit,
  input  logic                  rd,
  input  logic                  clr,
  output logic [7:0]            kbd_data,
  output logic [7:0]            kbd_flags,
  output logic [DEPTH_LOG2:0]   kbd_count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [7:0] CodeE0 = 8'hE0;
  localparam logic [7:0] CodeF0 = 8'hF0;

  typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} state_e;

  state_e                  r_state;
  logic                    r_rd_q;
  logic                    r_ovf;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [9:0]              r_mem [Depth];

  logic                    w_is_e0;
  logic                    w_is_f0;
  logic                    w_code_hit;
  logic                    w_nonempty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_ovf_set;
  logic [9:0]              w_entry;
  logic [9:0]              w_head;

  assign w_is_e0    = (ps2_data == CodeE0);
  assign w_is_f0    = (ps2_data == CodeF0);
  assign w_code_hit = ps2_hit & ~w_is_e0 & ~w_is_f0 & ~clr;
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == FullCount);
  assign w_pop      = rd & ~r_rd_q & w_nonempty & ~clr;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push     = w_code_hit & (~w_full | w_pop);
  assign w_ovf_set  = w_code_hit & w_full & ~w_pop;

  assign w_entry = {(r_state == StE0) || (r_state == StE0F0),
                    (r_state == StF0) || (r_state == StE0F0),
                    ps2_data};

  // Prefix state machine.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else if (clr) begin
      r_state <= StIdle;
    end else if (ps2_hit) begin
      if (w_is_e0) begin
        unique case (r_state)
          StIdle, StE0: r_state <= StE0;
          default:      r_state <= StE0F0;
        endcase
      end else if (w_is_f0) begin
        unique case (r_state)
          StIdle, StF0: r_state <= StF0;
          default:      r_state <= StE0F0;
        endcase
      end else begin
        // Code byte ends the event whether or not it fit in the FIFO.
        r_state <= StIdle;
      end
    end
  end

  // rd edge detector keeps sampling even during clr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_q <= 1'b0;
    end else begin
      r_rd_q <= rd;
    end
  end

  // Pointers, count and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = w_nonempty ? r_mem[r_rd_ptr] : 10'd0;

  assign kbd_data  = w_head[7:0];
  assign kbd_flags = {w_nonempty, r_ovf, w_head[8], w_head[9], 4'b0000};
  assign kbd_count = r_count;

endmodule

// File: tb/tb_kbd_fifo.sv
module tb_kbd_fifo;

  localparam int unsigned DL2 = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [7:0]     ps2_data = 8'h00;
  logic           ps2_hit = 1'b0;
  logic           rd = 1'b0;
  logic           clr = 1'b0;
  logic [7:0]     kbd_data;
  logic [7:0]     kbd_flags;
  logic [DL2:0]   kbd_count;

  int checks = 0;
  int failures = 0;

  kbd_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_data  (ps2_data),
    .ps2_hit   (ps2_hit),
    .rd        (rd),
    .clr       (clr),
    .kbd_data  (kbd_data),
    .kbd_flags (kbd_flags),
    .kbd_count (kbd_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [7:0] f,
                         input logic [7:0] c);
    chk({tag, ".data"}, kbd_data, d);
    chk({tag, ".flags"}, kbd_flags, f);
    chk({tag, ".count"}, 8'(kbd_count), c);
  endtask

  // Strobe one byte; returns on the falling edge after the capturing rising edge.
  task automatic hit(input logic [7:0] b);
    @(negedge clock);
    ps2_data = b;
    ps2_hit  = 1'b1;
    @(negedge clock);
    ps2_hit  = 1'b0;
  endtask

  // One-cycle rd pulse; the following low cycle re-arms the edge detector.
  task automatic pop();
    @(negedge clock);
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  task automatic flush();
    @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
  endtask

  initial begin
    // Reset state, outputs held at zero during reset.
    repeat (3) @(negedge clock);
    chk_out("in_reset", 8'h00, 8'h00, 8'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk_out("after_reset", 8'h00, 8'h00, 8'd0);

    // Single push and pop.
    hit(8'h1C);
    chk_out("push_1c", 8'h1C, 8'h80, 8'd1);
    pop();
    chk_out("pop_1c", 8'h00, 8'h00, 8'd0);
    pop();
    chk_out("pop_empty", 8'h00, 8'h00, 8'd0);

    // Prefix folding.
    hit(8'hE0);
    chk_out("prefix_only", 8'h00, 8'h00, 8'd0);
    hit(8'hF0);
    hit(8'h75);
    hit(8'hF0);
    hit(8'h1C);
    hit(8'hE0);
    hit(8'h75);
    chk_out("prefix_3", 8'h75, 8'hB0, 8'd3);
    pop();
    chk_out("prefix_pop1", 8'h1C, 8'hA0, 8'd2);
    pop();
    chk_out("prefix_pop2", 8'h75, 8'h90, 8'd1);
    pop();
    chk_out("prefix_pop3", 8'h00, 8'h00, 8'd0);

    // Overflow: 17 pushes into 16 slots.
    for (int i = 1; i <= 17; i++) hit(8'(i));
    chk_out("full", 8'h01, 8'hC0, 8'd16);
    for (int i = 1; i <= 16; i++) begin
      chk("ovf_drain.data", kbd_data, 8'(i));
      pop();
    end
    chk_out("ovf_drained", 8'h00, 8'h40, 8'd0);
    hit(8'h5A);
    chk_out("ovf_sticky", 8'h5A, 8'hC0, 8'd1);
    flush();
    chk_out("ovf_clr", 8'h00, 8'h00, 8'd0);

    // Long rd level pops exactly once.
    hit(8'h21);
    hit(8'h22);
    hit(8'h23);
    @(negedge clock);
    rd = 1'b1;
    repeat (10) @(negedge clock);
    rd = 1'b0;
    chk_out("long_rd", 8'h22, 8'h80, 8'd2);
    flush();
    chk_out("long_rd_clr", 8'h00, 8'h00, 8'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) hit(8'h30 + 8'(i));
    chk_out("fill16", 8'h30, 8'h80, 8'd16);
    @(negedge clock);
    ps2_data = 8'h2A;
    ps2_hit  = 1'b1;
    rd       = 1'b1;
    @(negedge clock);
    ps2_hit  = 1'b0;
    rd       = 1'b0;
    chk_out("full_pushpop", 8'h31, 8'h80, 8'd16);
    for (int i = 0; i < 15; i++) pop();
    chk_out("last_is_2a", 8'h2A, 8'h80, 8'd1);
    pop();
    chk_out("drained_2a", 8'h00, 8'h00, 8'd0);

    // Empty FIFO with simultaneous push and pop: push lands.
    @(negedge clock);
    ps2_data = 8'h44;
    ps2_hit  = 1'b1;
    rd       = 1'b1;
    @(negedge clock);
    ps2_hit  = 1'b0;
    rd       = 1'b0;
    chk_out("empty_pushpop", 8'h44, 8'h80, 8'd1);

    // clr discards a same-cycle hit.
    @(negedge clock);
    clr      = 1'b1;
    ps2_data = 8'h55;
    ps2_hit  = 1'b1;
    @(negedge clock);
    clr      = 1'b0;
    ps2_hit  = 1'b0;
    chk_out("clr_hit", 8'h00, 8'h00, 8'd0);

    // Asynchronous reset mid-operation drops entries and pending prefix.
    hit(8'h12);
    hit(8'hE0);
    #1 reset_n = 1'b0;
    #1 chk_out("async_reset", 8'h00, 8'h00, 8'd0);
    #1 reset_n = 1'b1;
    hit(8'h6B);
    chk_out("after_prefix_reset", 8'h6B, 8'h80, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
